// File: rtl/alu_result_skid.sv
// EX->MEM boundary register: two-entry skid buffer with valid/ready on both sides.
// Optional stall counter enabled by defining ALU_SKID_STALLCNT_EN.
module alu_result_skid #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              in_branch_en,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic              out_branch_en,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [31:0]       stall_count
);

  localparam int PAY_W = DATA_W + RD_W + 4;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state_reg;
  logic [PAY_W-1:0] head_reg;
  logic [PAY_W-1:0] skid_reg;
  logic [PAY_W-1:0] in_payload;
  logic             push;
  logic             pop;

  assign in_payload = {in_alu_result, in_branch_en, in_rd,
                       in_reg_write, in_mem_read, in_mem_write};

  // in_ready depends only on the state register, never on out_ready
  assign in_ready  = (state_reg != FULL) & reset_n;
  assign out_valid = (state_reg != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign {out_alu_result, out_branch_en, out_rd,
          out_reg_write, out_mem_read, out_mem_write} = head_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      skid_reg  <= '0;
    end else if (flush) begin
      // Only validity is dropped; payload registers keep their contents
      state_reg <= EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (push) begin
            head_reg  <= in_payload;
            state_reg <= ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            skid_reg  <= in_payload;
            state_reg <= FULL;
          end else if (!push && pop) begin
            state_reg <= EMPTY;
          end else if (push && pop) begin
            head_reg  <= in_payload;
          end
        end
        FULL: begin
          if (pop) begin
            head_reg  <= skid_reg;
            state_reg <= ONE;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

`ifdef ALU_SKID_STALLCNT_EN
  logic [31:0] stall_count_reg;

  // Free-running wrap at 2^32; flush deliberately leaves it alone
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_reg <= '0;
    end else if (out_valid && !out_ready) begin
      stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  assign stall_count = stall_count_reg;
`else
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_alu_result_skid.sv
// Scoreboard bench for alu_result_skid: directed vectors, queue-based monitor.
module tb_alu_result_skid;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_result;
  logic        in_branch_en;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_result;
  logic        out_branch_en;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [40:0] exp_q[$];

  alu_result_skid #(.DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_branch_en(in_branch_en), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_branch_en(out_branch_en), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Monitor: one line per consumed entry, compared against the scoreboard head
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      logic [40:0] act;
      act = {out_alu_result, out_branch_en, out_rd, out_reg_write, out_mem_read, out_mem_write};
      pops++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual=%0h required=none", act);
      end else begin
        logic [40:0] exp;
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL pop_data actual=%0h required=%0h", act, exp);
        end else begin
          $display("pop  %0h", act);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [40:0] mk(input int i);
    logic [31:0] v;
    v = i;
    return {32'hA000_0000 + v, v[0], v[4:0], ~v[1], v[2], v[3]};
  endfunction

  // Offer one entry; waits (bounded) for in_ready, books it, then clocks it in
  task automatic send(input logic [40:0] p, output int waited);
    waited = 0;
    in_valid = 1'b1;
    {in_alu_result, in_branch_en, in_rd, in_reg_write, in_mem_read, in_mem_write} = p;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=0 required=1");
    end else begin
      exp_q.push_back(p);
    end
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int w;
    int wsum;
    int p0;
    logic [31:0] sc0;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    {in_alu_result, in_branch_en, in_rd, in_reg_write, in_mem_read, in_mem_write} = '0;
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_stall_count", 64'(stall_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    step();

    // 1: single push with out_ready high
    out_ready = 1'b1;
    send({32'h1234, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0}, w);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_result", 64'(out_alu_result), 64'h1234);
    check("t1_rd", 64'(out_rd), 64'd5);
    check("t1_reg_write", 64'(out_reg_write), 64'd1);
    step();
    check("t1_empty_after", 64'(out_valid), 64'd0);

    // 2: fill both entries under backpressure, then drain
    out_ready = 1'b0;
    send({32'h11, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0}, w);
    send({32'h22, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1}, w);
    check("t2_in_ready_full", 64'(in_ready), 64'd0);
    check("t2_head_A", 64'(out_alu_result), 64'h11);
    p0 = pops;
    out_ready = 1'b1;
    step();
    check("t2_second_head_B", 64'(out_alu_result), 64'h22);
    check("t2_in_ready_back", 64'(in_ready), 64'd1);
    step();
    check("t2_drained", 64'(pops - p0), 64'd2);

    // 3: streaming at full rate
    p0 = pops; wsum = 0;
    for (int i = 0; i < 100; i++) begin
      send(mk(i), w);
      wsum += w;
    end
    step(); step();
    check("t3_no_backpressure", 64'(wsum), 64'd0);
    check("t3_pop_count", 64'(pops - p0), 64'd100);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // 4a: flush while FULL, C offered but refused
    out_ready = 1'b0;
    send(mk(200), w);
    send(mk(201), w);
    in_valid = 1'b1;
    {in_alu_result, in_branch_en, in_rd, in_reg_write, in_mem_read, in_mem_write} = mk(202);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("t4a_out_valid", 64'(out_valid), 64'd0);
    check("t4a_in_ready", 64'(in_ready), 64'd1);
    // 4b: flush while ONE with a pop and an acceptable input in the same cycle
    send(mk(210), w);
    out_ready = 1'b1;
    in_valid = 1'b1;
    {in_alu_result, in_branch_en, in_rd, in_reg_write, in_mem_read, in_mem_write} = mk(211);
    p0 = pops;
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t4b_pop_completed", 64'(pops - p0), 64'd1);
    check("t4b_out_valid", 64'(out_valid), 64'd0);
    step(); step(); step();
    check("t4b_no_ghosts", 64'(pops - p0), 64'd1);
    send(mk(220), w);
    step();
    check("t4_post_flush_flow", 64'(exp_q.size()), 64'd0);

    // 6: stall counter while one entry is held
    out_ready = 1'b0;
    send(mk(230), w);
    sc0 = stall_count;
    repeat (7) step();
`ifdef ALU_SKID_STALLCNT_EN
    check("t6_stall_delta", 64'(stall_count - sc0), 64'd7);
`else
    check("t6_stall_zero", 64'(stall_count), 64'd0);
`endif
    out_ready = 1'b1;
    step();
    check("t6_drained", 64'(exp_q.size()), 64'd0);

    // 5: asynchronous reset while FULL
    out_ready = 1'b0;
    send(mk(240), w);
    send(mk(241), w);
    check("t5_full_before", 64'(in_ready), 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_result", 64'(out_alu_result), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd0);
    check("t5_stall_count", 64'(stall_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("t5_in_ready_release", 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b1;
    send(mk(250), w);
    step();
    check("t5_recovered", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
